adder_serial_seq: RTL and testbench

ADDER_SERIAL_SEQ -- requirements
Module: adder_serial_seq

---
 rtl/adder_serial_seq.sv | 126 ++++++++++++
 tb/tb_adder_serial_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/adder_serial_seq.sv
// Bit-serial unsigned adder: {c_out, sum} = a + b + c_in, one bit per clock, LSB first,
// built around a single 1-bit full-adder cell with a valid/ready handshake on each side.

module FullAdderCell (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module adder_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cellSum, cellCarry;
  logic [WIDTH-1:0] sumShifted;

  FullAdderCell u_cell (
    .x     (a_q[0]),
    .y     (b_q[0]),
    .c_in  (carry_q),
    .sum   (cellSum),
    .c_out (cellCarry)
  );

  // Each new sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign sumShifted = cellSum;
    end else begin : g_wide
      assign sumShifted = {cellSum, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        sum_d   = sumShifted;
        carry_d = cellCarry;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // The carry flop holds the final carry once RUN completes, so it doubles as c_out.
  assign sum   = sum_q;
  assign c_out = carry_q;

endmodule

// File: tb/tb_adder_serial_seq.sv
// Directed bench for adder_serial_seq (WIDTH=8): results are predicted into a scoreboard
// queue when operands are driven and compared when the DUT presents them.

module tb_adder_serial_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       c_out;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] sb[$];

  adder_serial_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] predict(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    return {1'b0, av} + {1'b0, bv} + {8'd0, cv};
  endfunction

  function automatic logic [8:0] popExpected();
    if (sb.size() == 0) return 9'bx;
    return sb.pop_front();
  endfunction

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                               input int holdCycles);
    int         edges;
    int         busyCount;
    logic [8:0] held;
    logic [8:0] exp;
    @(negedge clk);
    checkOutput("idle_ready", 32'(in_ready), 32'd1);
    a = av; b = bv; c_in = cv; in_valid = 1'b1;
    sb.push_back(predict(av, bv, cv));
    @(negedge clk);
    in_valid = 1'b0; a = ~av; b = ~bv; c_in = ~cv;
    edges = 0;
    busyCount = 0;
    while (!out_valid && edges < 40) begin
      if (busy) busyCount++;
      @(negedge clk);
      edges++;
    end
    checkOutput("latency", 32'(edges), 32'd8);
    checkOutput("busy_cycles", 32'(busyCount), 32'd8);
    held = {c_out, sum};
    for (int i = 0; i < holdCycles; i++) begin
      a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom); in_valid = i[0];
      @(negedge clk);
      checkOutput("hold_stable", 32'({out_valid, in_ready, c_out, sum}), 32'({2'b10, held}));
    end
    in_valid = 1'b0;
    exp = popExpected();
    checkOutput("result", 32'({c_out, sum}), 32'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("back_idle", 32'({in_ready, out_valid, busy}), 32'(3'b100));
  endtask

  initial begin
    int         results;
    int         cyc;
    int         lastCyc;
    logic [8:0] exp;
    logic [7:0] ra, rb;
    logic       rc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sum_cout", 32'({c_out, sum}), 32'd0);
    rst = 1'b0;

    applyStimulus(8'h3C, 8'h0F, 1'b0, 0);
    applyStimulus(8'hFF, 8'h01, 1'b0, 0);
    applyStimulus(8'hA5, 8'h5A, 1'b1, 0);
    applyStimulus(8'h00, 8'h00, 1'b0, 0);
    applyStimulus(8'h12, 8'hE7, 1'b1, 5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), i);
    end

    // Reset in the 4th RUN cycle, with in_valid and out_ready also high, must abort cleanly.
    @(negedge clk);
    a = 8'h77; b = 8'h99; c_in = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("abort_state", 32'({in_ready, out_valid, busy}), 32'(3'b100));
    checkOutput("abort_sum_cout", 32'({c_out, sum}), 32'd0);
    @(negedge clk);
    checkOutput("abort_still_idle", 32'({in_ready, busy}), 32'(2'b10));
    applyStimulus(8'h80, 8'h80, 1'b0, 0);

    // Back-to-back stream with in_valid held high.
    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
    a = ra; b = rb; c_in = rc;
    sb.push_back(predict(ra, rb, rc));
    in_valid = 1'b1; out_ready = 1'b1;
    results = 0; cyc = 0; lastCyc = -1;
    while (results < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        exp = popExpected();
        checkOutput("stream_result", 32'({c_out, sum}), 32'(exp));
        if (lastCyc >= 0) checkOutput("stream_period", 32'(cyc - lastCyc), 32'd10);
        lastCyc = cyc;
        results++;
        if (results == 5) in_valid = 1'b0;
      end
      if (in_ready && in_valid) begin
        ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
        a = ra; b = rb; c_in = rc;
        sb.push_back(predict(ra, rb, rc));
      end
    end
    checkOutput("stream_count", 32'(results), 32'd5);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("stream_idle", 32'({in_ready, out_valid, busy}), 32'(3'b100));
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
